// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared widths, step count, FSM state type and sign-extend
//                helper for the radix-2 Booth multiplier controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  localparam int WIDTH_IN = 16;
  localparam int WIDTH_PP = 33;
  localparam int STEPS    = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // Extend an operand by one sign bit so an add/sub of two full-range values
  // (including -32768) always fits.
  function automatic logic [WIDTH_IN:0] sext_guard(input logic [WIDTH_IN-1:0] v);
    return {v[WIDTH_IN-1], v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_step_alu.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step_alu
//  Description : One radix-2 Booth step: recode the two low bits of the
//                partial product, add/sub the multiplicand into the upper
//                half with a 17-bit guard, then arithmetic shift right by one.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step_alu
  import booth_pkg::*;
(
  input  logic [WIDTH_PP-1:0] pp_i,
  input  logic [WIDTH_IN-1:0] a_i,
  output logic [WIDTH_PP-1:0] pp_next_o
);

  logic [WIDTH_IN:0] upper_x;
  logic [WIDTH_IN:0] a_x;
  logic [WIDTH_IN:0] sum17;

  // Recode, accumulate in the guarded upper half, and shift right by one.
  always_comb begin
    upper_x = sext_guard(pp_i[WIDTH_PP-1:WIDTH_IN+1]);
    a_x     = sext_guard(a_i);
    sum17   = upper_x;
    unique case (pp_i[1:0])
      2'b01:   sum17 = upper_x + a_x;
      2'b10:   sum17 = upper_x - a_x;
      default: sum17 = upper_x;
    endcase
    // The guard bit of sum17 becomes the new sign bit, so the shift is
    // arithmetic and never overflows.
    pp_next_o = {sum17, pp_i[WIDTH_IN:1]};
  end

endmodule
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
//  Module      : booth_controller
//  Description : Sequencer for the radix-2 Booth multiplier. Accepts an
//                operand pair, drives ld / en / ld_p of the external
//                partial_product register for 16 steps, and presents the
//                32-bit signed product over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_controller
  import booth_pkg::*;
#(
  parameter int Width_in = 16,
  parameter int Width_PP = 33
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [Width_in-1:0]     in_A,
  input  logic [Width_in-1:0]     in_B,
  input  logic [Width_PP-1:0]     pp_in,
  output logic [Width_PP-1:0]     pp_next,
  output logic                    ld,
  output logic                    ld_p,
  output logic                    en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*Width_in-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  booth_state_e          state_q;
  booth_state_e          state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [Width_in-1:0]   a_q;

  // in_B is routed straight to partial_product at the top level; the
  // controller itself never needs it.
  logic unused_in_b;
  assign unused_in_b = ^in_B;

  // State register: reset always lands in IDLE and discards any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> 16 steps -> hold result until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP)  state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output logic: every control is gated by reset so nothing fires in the
  // reset cycle, and ld / ld_p come from mutually exclusive states.
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    ld        = in_valid && in_ready;
    en        = (state_q == RUN) && !reset;
    out_valid = (state_q == DONE) && !reset;
    ld_p      = out_valid && out_ready;
    product   = out_valid ? pp_in[Width_PP-1:1] : '0;
  end

  // Step counter and multiplicand capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
    end else if (ld) begin
      cnt_q <= '0;
      a_q   <= in_A;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  booth_step_alu u_step_alu (
    .pp_i      (pp_in),
    .a_i       (a_q),
    .pp_next_o (pp_next)
  );

endmodule
`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_controller
//  Description : Self-checking bench for booth_controller with a stand-in
//                partial_product register and an arithmetic product model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic [32:0] pp_in;
  logic [32:0] pp_next;
  logic        ld;
  logic        ld_p;
  logic        en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_controller #(.Width_in(16), .Width_PP(33)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .pp_in     (pp_in),
    .pp_next   (pp_next),
    .ld        (ld),
    .ld_p      (ld_p),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // Downstream partial_product register as it sits next to the controller.
  always @(posedge clk) begin
    if (reset)      pp_in <= '0;
    else if (ld_p)  pp_in <= '0;
    else if (ld)    pp_in <= {16'h0, in_B, 1'b0};
    else if (en)    pp_in <= pp_next;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the product is simply the signed integer product.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 32'(ia * ib);
  endfunction

  // One full operation: accept, 16 steps, optional backpressure, handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input bit busy_valid, input bit chk_space);
    logic [31:0] exp;
    exp = ref_mul(a, b);
    @(negedge clk);
    in_valid = 1'b1; in_A = a; in_B = b; out_ready = 1'b0;
    #1;
    check("accept_in_ready", in_ready, 1);
    check("accept_ld", ld, 1);
    check("accept_ld_p", ld_p, 0);
    if (chk_space) check("accept_spacing", cyc - acc_cyc, 18);
    acc_cyc = cyc;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (busy_valid) begin
        in_valid = 1'b1; in_A = 16'd9; in_B = 16'd9;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("run_en", en, 1);
      check("run_in_ready", in_ready, 0);
      check("run_ld", ld, 0);
      check("run_ld_p", ld_p, 0);
      check("run_out_valid", out_valid, 0);
      check("run_product", product, 0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      out_ready = (h == hold);
      #1;
      check("done_out_valid", out_valid, 1);
      check("done_product", product, exp);
      check("done_en", en, 0);
      check("done_in_ready", in_ready, 0);
      check("done_ld", ld, 0);
      check("done_ld_p", ld_p, (h == hold) ? 1 : 0);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_en", en, 0);
    check("idle_product", product, 0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    reset = 1'b1; in_valid = 1'b1; in_A = 16'd1; in_B = 16'd1; out_ready = 1'b1;

    // Reset state: all controls held low, including in_ready.
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_ld", ld, 0);
      check("rst_ld_p", ld_p, 0);
      check("rst_en", en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed products.
    run_op(16'd3, 16'd5, 0, 1'b0, 1'b0);
    idle_check();
    run_op(-16'sd7, 16'd6, 0, 1'b0, 1'b0);
    idle_check();
    run_op(16'h8000, 16'h8000, 0, 1'b0, 1'b0);
    idle_check();
    run_op(16'h7FFF, 16'h8000, 0, 1'b0, 1'b0);
    idle_check();

    // Backpressure for 5 cycles.
    run_op(16'd3, 16'd5, 5, 1'b0, 1'b0);
    idle_check();

    // in_valid with other operands during RUN/DONE is ignored.
    run_op(16'd3, 16'd5, 2, 1'b1, 1'b0);
    idle_check();

    // Reset partway through an operation.
    @(negedge clk);
    in_valid = 1'b1; in_A = 16'd11; in_B = 16'd13; out_ready = 1'b1;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("midrun_en", en, 1);
    reset = 1'b1;
    #1;
    check("midrun_rst_en", en, 0);
    check("midrun_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_en", en, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("after_rst_no_valid", out_valid, 0);
    end
    run_op(16'd2, -16'sd4, 0, 1'b0, 1'b0);

    // Back-to-back with in_valid held high: accepts every 18 cycles.
    run_op(16'd100, -16'sd3, 0, 1'b1, 1'b1);
    run_op(-16'sd250, -16'sd250, 0, 1'b1, 1'b1);
    run_op(16'd1, 16'h7FFF, 0, 1'b1, 1'b1);
    idle_check();

    // Randomized operands and backpressure.
    for (int k = 0; k < 10; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_controller.md
# booth_controller

Sequencer and step datapath for the radix-2 Booth multiplier. Accepts a signed 16×16 operand pair over a valid/ready handshake and drives the `ld`, `ld_p` and `en` controls of the downstream `partial_product` register. Computes that register's next value (`pp_next`) from its current output, one add/sub-and-shift per cycle. Presents the 32-bit signed product over a second valid/ready handshake.

## Interface
Parameters:
- `Width_in`, 16: operand width; supported value is 16 only.
- `Width_PP`, 33: partial-product width; must equal 2·`Width_in`+1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: controller can accept an operand pair.
- `in_A`, input, 16: signed multiplicand.
- `in_B`, input, 16: signed multiplier; the top level also wires it to `partial_product.in_B`.
- `pp_in`, input, 33: current partial product, from `partial_product.out`.
- `pp_next`, output, 33: next partial product, to `partial_product.in`.
- `ld`, output, 1: load initial partial product.
- `ld_p`, output, 1: clear partial product.
- `en`, output, 1: update partial product with `pp_next`.
- `out_valid`, output, 1: product valid.
- `out_ready`, input, 1: consumer accepts the product.
- `product`, output, 32: signed product.

## Operation
- States: IDLE, RUN, DONE. There is a 4-bit step counter `cnt` and a 16-bit multiplicand register `a_q`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_A` into `a_q`, clear `cnt`, go to RUN.
  - `ld` = `in_valid && in_ready` (combinational). `partial_product` therefore loads {16'h0, in_B, 1'b0} on the same edge.
- RUN:
  - `en`=1 and `cnt` increments every cycle.
  - When `cnt`==15, go to DONE. Exactly 16 `en` cycles occur.
- DONE:
  - `out_valid`=1.
  - On `out_valid && out_ready`: assert `ld_p` (combinational) and go to IDLE. `ld_p` clears the partial product.
- Step arithmetic (`pp_next`, purely combinational, valid in every state):
  - `upper` = `pp_in[32:17]`; `q` = `pp_in[1:0]`.
  - `sum17` is computed as follows:
    - `q`=01: sext17(`upper`) + sext17(`a_q`).
    - `q`=10: sext17(`upper`) − sext17(`a_q`).
    - `q`=00 or 11: sext17(`upper`).
  - `pp_next` = {`sum17`, `pp_in[16:1]`}. This is an arithmetic right shift with a 17-bit guard, so `in_A` = −32768 never overflows.
- `product` = `pp_in[32:1]` while `out_valid`; otherwise 0.
- `in_valid` in RUN or DONE is ignored (`in_ready`=0); the operands are not latched.
- `ld` and `ld_p` are never asserted in the same cycle. A new accept is possible at the earliest one cycle after the output handshake.

## Timing
- Reset values while `reset`=1 and on the following cycle:
  - State IDLE, `cnt`=0, `a_q`=0.
  - `in_ready`=0 during the reset cycle, then 1.
  - `ld`=`ld_p`=`en`=0, `out_valid`=0, `product`=0.
- Latency:
  - Accept at edge E0.
  - `en` is high in the 16 cycles after E0.
  - `out_valid` rises in the 17th cycle after E0 and holds until `out_ready`.
- Backpressure: while `out_valid` && !`out_ready`, `product` is stable and `en`=0.
- Reset mid-RUN or mid-DONE: return to IDLE next cycle, discard the operation, and produce no `out_valid`. `partial_product` shares `reset` and clears on the same edge.
- Throughput: one product per 18 cycles minimum (accept, 16 steps, output handshake).

## Structure
- Shared package `booth_pkg`:
  - `WIDTH_IN`=16, `WIDTH_PP`=33.
  - `booth_state_e` (IDLE, RUN, DONE).
  - `STEPS`=16.
- Sub-module `booth_step_alu`: the combinational recode/add-sub/shift producing `pp_next` from `pp_in` and `a_q`.
- The FSM, counter and `a_q` live in `booth_controller`. The top level instantiates `booth_controller` and `partial_product` side by side.

## Test plan
- A=3, B=5, `out_ready`=1 → `out_valid` 17 cycles after accept, `product`=32'h0000000F, `ld_p` pulses once.
- A=−7, B=6 → `product`=32'hFFFFFFD6. A=−32768, B=−32768 → 32'h40000000. A=32767, B=−32768 → 32'hC0008000.
- `out_ready`=0 for 5 cycles in DONE → `product` and `out_valid` held constant, `en`=0, `in_ready`=0.
- `in_valid` asserted with A=9, B=9 during RUN of a 3×5 operation → ignored, result still 15, `in_ready` stays 0 until after the output handshake.
- `reset` pulsed at step 8 of an operation → next cycle IDLE, `out_valid` never asserts, a subsequent 2×−4 yields 32'hFFFFFFF8.
- Back-to-back operations with `out_ready`=1 and `in_valid` always high → accepts spaced exactly 18 cycles; `ld` and `ld_p` never coincide.
